// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/interrupt controller: prioritised IRQ/overflow entry, EPC/cause capture, iret return
// Optional macro IRQ_SYNC_EN adds a 2-flop synchronizer per irq line ahead of edge detection.
module exc_ctrl #(
  parameter int unsigned NUM_IRQ      = 4,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0040
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               interrupt_en,
  input  logic               over_flow,
  input  logic               ex_valid,
  input  logic [31:0]        ex_pc,
  input  logic               iret,
  input  logic               stall,
  output logic               flush,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic [31:0]        epc,
  output logic [7:0]         cause,
  output logic               in_handler,
  output logic [NUM_IRQ-1:0] irq_pending
);

  typedef enum logic {S_RUN, S_HANDLER} state_t;

  localparam logic [1:0] CODE_IRQ = 2'd1;
  localparam logic [1:0] CODE_OVF = 2'd2;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_s, irq_prev_q, new_edges;
  logic [NUM_IRQ-1:0] pending_q, pending_d, take_mask;
  logic [31:0]        epc_q, epc_d;
  logic [7:0]         cause_q, cause_d;
  logic               flush_q, flush_d;
  logic [31:0]        redirect_pc_q, redirect_pc_d;
  logic [2:0]         take_id;
  logic               accept_ok;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  // Synchronizer preloads the raw lines so a line held high through reset is not a request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= irq;
      sync2_q <= irq;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq;
`endif

  assign new_edges = irq_s & ~irq_prev_q;
  assign take_mask = pending_q & (~pending_q + NUM_IRQ'(1));

  always_comb begin
    take_id = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending_q[i]) take_id = 3'(i);
    end
  end

  // The cycle after a redirect carries squashed work, so no accept or return happens in it.
  assign accept_ok = ex_valid & ~stall & ~flush_q;

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q | new_edges;
    epc_d         = epc_q;
    cause_d       = cause_q;
    flush_d       = 1'b0;
    redirect_pc_d = '0;
    unique case (state_q)
      S_RUN: begin
        if (over_flow && accept_ok) begin
          epc_d         = ex_pc;
          cause_d       = {cause_q[7], CODE_OVF, 5'd0};
          flush_d       = 1'b1;
          redirect_pc_d = HANDLER_ADDR;
          state_d       = S_HANDLER;
        end else if (interrupt_en && accept_ok && (pending_q != '0)) begin
          pending_d     = (pending_q & ~take_mask) | new_edges;
          epc_d         = ex_pc;
          cause_d       = {cause_q[7], CODE_IRQ, 2'b00, take_id};
          flush_d       = 1'b1;
          redirect_pc_d = HANDLER_ADDR;
          state_d       = S_HANDLER;
        end
      end
      S_HANDLER: begin
        if (over_flow && ex_valid) cause_d[7] = 1'b1;
        if (iret && accept_ok) begin
          flush_d       = 1'b1;
          redirect_pc_d = (cause_q[6:5] == CODE_OVF) ? epc_q + 32'd4 : epc_q;
          state_d       = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RUN;
      irq_prev_q    <= irq;
      pending_q     <= '0;
      epc_q         <= '0;
      cause_q       <= '0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      irq_prev_q    <= irq_s;
      pending_q     <= pending_d;
      epc_q         <= epc_d;
      cause_q       <= cause_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign flush          = flush_q;
  assign redirect_valid = flush_q;
  assign redirect_pc    = redirect_pc_q;
  assign epc            = epc_q;
  assign cause          = cause_q;
  assign in_handler     = (state_q == S_HANDLER);
  assign irq_pending    = pending_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - self-checking bench for exc_ctrl: cycle model plus directed literal checks
module tb_exc_ctrl;
  localparam int N = 4;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  irq = '0;
  logic          interrupt_en = 1'b0, over_flow = 1'b0, ex_valid = 1'b0, iret = 1'b0, stall = 1'b0;
  logic [31:0]   ex_pc = '0;
  logic          flush, redirect_valid, in_handler;
  logic [31:0]   redirect_pc, epc;
  logic [7:0]    cause;
  logic [N-1:0]  irq_pending;

  int checks = 0;
  int errors = 0;

  exc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .interrupt_en(interrupt_en),
    .over_flow(over_flow), .ex_valid(ex_valid), .ex_pc(ex_pc), .iret(iret),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .epc(epc), .cause(cause),
    .in_handler(in_handler), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Behavioural model: a handler flag, a pending set, saved PC and cause fields.
  bit           m_inh = 0, m_nest = 0, m_flush = 0, ok, found;
  logic [N-1:0] m_pend = '0, m_prev = '0, m_s1 = '0, m_s2 = '0, m_s, edges;
  logic [31:0]  m_epc = '0, m_rpc = '0;
  logic [1:0]   m_code = '0;
  logic [2:0]   m_id = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_inh = 0; m_nest = 0; m_flush = 0; m_pend = '0;
      m_epc = '0; m_rpc = '0; m_code = '0; m_id = '0;
      m_prev = irq; m_s1 = irq; m_s2 = irq;
    end else begin
`ifdef IRQ_SYNC_EN
      m_s = m_s2; m_s2 = m_s1; m_s1 = irq;
`else
      m_s = irq;
`endif
      edges  = m_s & ~m_prev;
      m_prev = m_s;
      ok      = ex_valid && !stall && !m_flush;
      m_flush = 0;
      if (!m_inh) begin
        if (over_flow && ok) begin
          m_epc = ex_pc; m_code = 2; m_id = 0; m_rpc = 32'h40; m_flush = 1; m_inh = 1;
        end else if (interrupt_en && ok && m_pend != 0) begin
          found = 0;
          for (int i = 0; i < N; i++) begin
            if (!found && m_pend[i]) begin
              found = 1; m_id = 3'(i); m_pend[i] = 1'b0;
            end
          end
          m_epc = ex_pc; m_code = 1; m_rpc = 32'h40; m_flush = 1; m_inh = 1;
        end
      end else begin
        if (over_flow && ex_valid) m_nest = 1;
        if (iret && ok) begin
          m_rpc = (m_code == 2) ? m_epc + 32'd4 : m_epc;
          m_flush = 1; m_inh = 0;
        end
      end
      m_pend = m_pend | edges;
    end
    #1;
    lit("cmp_flush", 32'(flush), 32'(m_flush));
    lit("cmp_redirect_valid", 32'(redirect_valid), 32'(m_flush));
    lit("cmp_in_handler", 32'(in_handler), 32'(m_inh));
    lit("cmp_irq_pending", 32'(irq_pending), 32'(m_pend));
    lit("cmp_epc", epc, m_epc);
    lit("cmp_cause", 32'(cause), 32'({m_nest, m_code, 2'b00, m_id}));
    if (m_flush) lit("cmp_redirect_pc", redirect_pc, m_rpc);
  end

  initial begin
    cyc(2);
    lit("rst_flush", 32'(flush), 32'd0);
    lit("rst_cause", 32'(cause), 32'd0);
    lit("rst_in_handler", 32'(in_handler), 32'd0);
    rst_n = 1'b1;

    // Overflow entry and return past the faulting instruction
    ex_valid = 1; ex_pc = 32'h100; over_flow = 1;
    cyc(1); over_flow = 0; ex_valid = 0;
    lit("ovf_flush", 32'(flush), 32'd1);
    lit("ovf_rpc", redirect_pc, 32'h40);
    lit("ovf_epc", epc, 32'h100);
    lit("ovf_cause", 32'(cause), 32'h40);
    lit("ovf_in_handler", 32'(in_handler), 32'd1);
    cyc(1); ex_valid = 1; iret = 1; ex_pc = 32'h40;
    cyc(1); iret = 0; ex_valid = 0;
    lit("ovf_ret_flush", 32'(flush), 32'd1);
    lit("ovf_ret_rpc", redirect_pc, 32'h104);
    lit("ovf_ret_in_handler", 32'(in_handler), 32'd0);
    cyc(1);

    // IRQ 2 entry latency and return to the squashed instruction
    interrupt_en = 1; ex_valid = 1; ex_pc = 32'h200; irq = 4'b0100;
    for (int k = 1; k < LAT; k++) begin
      cyc(1);
      lit("irq_early_flush", 32'(flush), 32'd0);
    end
    cyc(1); ex_valid = 0;
    lit("irq_flush", 32'(flush), 32'd1);
    lit("irq_epc", epc, 32'h200);
    lit("irq_cause", 32'(cause), 32'h22);
    lit("irq_pending_clr", 32'(irq_pending), 32'd0);
    irq = '0;
    cyc(1); ex_valid = 1; iret = 1;
    cyc(1); iret = 0; ex_valid = 0;
    lit("irq_ret_rpc", redirect_pc, 32'h200);
    cyc(1);

    // Overflow beats pending IRQs; lowest pending taken afterwards
    irq = 4'b1010;
    cyc(LAT - 1);
    lit("pri_pending", 32'(irq_pending), 32'hA);
    over_flow = 1; ex_valid = 1; ex_pc = 32'h300;
    cyc(1); over_flow = 0; ex_valid = 0;
    lit("pri_cause", 32'(cause), 32'h40);
    lit("pri_pending_kept", 32'(irq_pending), 32'hA);
    cyc(1); ex_valid = 1; iret = 1;
    cyc(1); iret = 0; ex_valid = 0;
    lit("pri_ret_rpc", redirect_pc, 32'h304);
    cyc(1); ex_valid = 1; ex_pc = 32'h400;
    cyc(1); ex_valid = 0;
    lit("pri_irq1_flush", 32'(flush), 32'd1);
    lit("pri_irq1_cause", 32'(cause), 32'h21);
    lit("pri_irq3_left", 32'(irq_pending), 32'h8);
    cyc(1); ex_valid = 1; iret = 1;
    cyc(1); iret = 0; ex_valid = 0;
    lit("pri_irq1_ret", redirect_pc, 32'h400);
    cyc(1);

    // Gating: each of enable, stall and ex_valid blocks acceptance
    interrupt_en = 0; ex_valid = 1; ex_pc = 32'h500;
    cyc(1); lit("gate_en", 32'(flush), 32'd0);
    interrupt_en = 1; stall = 1;
    cyc(1); lit("gate_stall", 32'(flush), 32'd0);
    stall = 0; ex_valid = 0;
    cyc(1); lit("gate_valid", 32'(flush), 32'd0);
    ex_valid = 1;
    cyc(1); ex_valid = 0;
    lit("gate_take", 32'(flush), 32'd1);
    lit("gate_cause", 32'(cause), 32'h23);
    lit("gate_epc", epc, 32'h500);
    irq = '0;
    cyc(1); ex_valid = 1; iret = 1;
    cyc(1); iret = 0; ex_valid = 0;
    cyc(1);

    // Inside the handler: edges only pend, overflow sets the sticky bit, then reset
    over_flow = 1; ex_valid = 1; ex_pc = 32'h600;
    cyc(1); over_flow = 0; ex_valid = 0;
    cyc(1); irq = 4'b0001;
    cyc(LAT);
    lit("hdl_pending", 32'(irq_pending), 32'h1);
    lit("hdl_no_flush", 32'(flush), 32'd0);
    over_flow = 1; ex_valid = 1;
    cyc(1); over_flow = 0; ex_valid = 0;
    lit("hdl_nest_cause", 32'(cause), 32'hC0);
    lit("hdl_nest_no_flush", 32'(flush), 32'd0);
    lit("hdl_in_handler", 32'(in_handler), 32'd1);
    rst_n = 0;
    #1;
    lit("mid_rst_in_handler", 32'(in_handler), 32'd0);
    lit("mid_rst_cause", 32'(cause), 32'd0);
    lit("mid_rst_epc", epc, 32'd0);
    lit("mid_rst_pending", 32'(irq_pending), 32'd0);
    lit("mid_rst_rpc", redirect_pc, 32'd0);
    cyc(2); rst_n = 1;
    cyc(LAT + 2);
    lit("held_high_no_req", 32'(irq_pending), 32'd0);

    // Single-cycle pulse on irq[0]: flush appears exactly LAT edges later
    irq = '0;
    cyc(4);
    ex_valid = 1; ex_pc = 32'h700; irq = 4'b0001;
    cyc(1); irq = '0;
    for (int k = 2; k < LAT; k++) begin
      cyc(1);
      lit("pulse_early_flush", 32'(flush), 32'd0);
    end
    cyc(1); ex_valid = 0;
    lit("pulse_flush", 32'(flush), 32'd1);
    lit("pulse_cause", 32'(cause), 32'h20);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
